// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FASTPATH_EN: divide-by-zero, signed overflow and zero-multiplicand ops skip BUSY.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  RegWrite_o,
    output logic [ADDR_WIDTH-1:0] write_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [5:0]            LAST  = 6'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  r_state, w_next;
    logic [2:0]              r_funct3;
    logic [ADDR_WIDTH-1:0]   r_rd;
    logic [DATA_WIDTH-1:0]   r_opnd;   // multiplicand (mul) or divisor (div) magnitude
    logic [DATA_WIDTH-1:0]   r_acc;    // product high half / partial remainder
    logic [DATA_WIDTH-1:0]   r_lo;     // multiplier bits -> product low half / dividend -> quotient
    logic                    r_a_neg, r_b_neg, r_div0;
    logic [5:0]              r_cnt;

    logic                    w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_div0, w_skip;
    logic [DATA_WIDTH-1:0]   w_a_mag, w_b_mag, w_lo_norm, w_opnd, w_lo_init, w_acc_init;
    logic [DATA_WIDTH:0]     w_sum, w_shift, w_diff;
    logic                    w_ge, w_neg_res;
    logic [2*DATA_WIDTH-1:0] w_prod, w_prod_s;
    logic [DATA_WIDTH-1:0]   w_quot, w_rem, w_result;

    // Signedness: MULH/DIV/REM treat both operands as signed, MULHSU only rs1.
    assign w_a_signed = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                        (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign w_b_signed = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign w_a_neg    = w_a_signed & operand_a_i[DATA_WIDTH-1];
    assign w_b_neg    = w_b_signed & operand_b_i[DATA_WIDTH-1];
    assign w_a_mag    = w_a_neg ? -operand_a_i : operand_a_i;
    assign w_b_mag    = w_b_neg ? -operand_b_i : operand_b_i;
    assign w_div0     = funct3_i[2] & (operand_b_i == '0);
    assign w_lo_norm  = funct3_i[2] ? w_a_mag : w_b_mag;
    assign w_opnd     = funct3_i[2] ? w_b_mag : w_a_mag;

`ifdef MULDIV_FASTPATH_EN
    logic w_ovf, w_mul0;
    assign w_ovf      = funct3_i[2] & ~funct3_i[0] & (operand_a_i == W_MIN) & (operand_b_i == '1);
    assign w_mul0     = ~funct3_i[2] & ((operand_a_i == '0) | (operand_b_i == '0));
    assign w_skip     = w_div0 | w_ovf | w_mul0;
    // Preload the final quotient/remainder or product so DONE can follow acceptance directly.
    assign w_lo_init  = w_div0 ? '1 : (w_mul0 ? '0 : w_lo_norm);
    assign w_acc_init = w_div0 ? w_a_mag : '0;
`else
    assign w_skip     = 1'b0;
    assign w_lo_init  = w_lo_norm;
    assign w_acc_init = '0;
`endif

    assign w_sum   = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_opnd : '0)};
    assign w_shift = {r_acc, r_lo[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_ge    = ~w_diff[DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start_i) begin
                r_funct3 <= funct3_i;
                r_rd     <= rd_addr_i;
                r_opnd   <= w_opnd;
                r_acc    <= w_acc_init;
                r_lo     <= w_lo_init;
                r_a_neg  <= w_a_neg;
                r_b_neg  <= w_b_neg;
                r_div0   <= w_div0;
                r_cnt    <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 6'd1;
                if (r_funct3[2]) begin
                    r_acc <= w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                    r_lo  <= {r_lo[DATA_WIDTH-2:0], w_ge};
                end else begin
                    r_acc <= w_sum[DATA_WIDTH:1];
                    r_lo  <= {w_sum[0], r_lo[DATA_WIDTH-1:1]};
                end
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = start_i;
                if (start_i) w_next = w_skip ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
    assign w_neg_res = r_a_neg ^ r_b_neg;
    assign w_prod    = {r_acc, r_lo};
    assign w_prod_s  = w_neg_res ? -w_prod : w_prod;
    assign w_quot    = (w_neg_res & ~r_div0) ? -r_lo : r_lo;
    assign w_rem     = r_a_neg ? -r_acc : r_acc;

    always_comb begin
        w_result = '0;
        case (r_funct3)
            3'b000:                 w_result = w_prod_s[DATA_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:         w_result = w_quot;
            default:                w_result = w_rem;
        endcase
    end

    assign result_o     = (r_state == S_DONE) ? w_result : '0;
    assign write_addr_o = (r_state == S_DONE) ? r_rd : '0;
    assign RegWrite_o   = done_o & (r_rd != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit with a result scoreboard and an independent RV32M model.
module tb_muldiv_unit;

    logic        clk, rst, start_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic        stall_o, busy_o, done_o, RegWrite_o;
    logic [31:0] result_o;
    logic [4:0]  write_addr_o;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];
    int total = 0;
    int bad   = 0;

`ifdef MULDIV_FASTPATH_EN
    localparam bit FAST_BUILD = 1'b1;
`else
    localparam bit FAST_BUILD = 1'b0;
`endif

    muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
        .rd_addr_i(rd_addr_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .RegWrite_o(RegWrite_o), .write_addr_o(write_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64, ub64, sp;
        logic [63:0] up;
        int sa, sb;
        sa = a;
        sb = b;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        up = {32'b0, a} * {32'b0, b};
        case (f)
            3'b000: return up[31:0];
            3'b001: begin sp = sa64 * sb64; return sp[63:32]; end
            3'b010: begin sp = sa64 * ub64; return sp[63:32]; end
            3'b011: return up[63:32];
            3'b100: if (b == 0) return 32'hFFFFFFFF;
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                    else return sa / sb;
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: if (b == 0) return a;
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                    else return sa % sb;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) return (b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return (a == 0) || (b == 0);
    endfunction

    // Drives one request, then follows it cycle by cycle until done_o (bounded).
    task automatic run_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input bit keep_start, input bit scramble);
        int cyc, stalls, exp_lat;
        bit got;
        logic [31:0] er;
        logic [4:0]  erd;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f; rd_addr_i = rd; operand_a_i = a; operand_b_i = b;
        exp_q.push_back(model(f, a, b));
        exp_rd_q.push_back(rd);
        exp_lat = (FAST_BUILD && is_fast(f, a, b)) ? 1 : 33;
        cyc = 0; stalls = 0; got = 1'b0;
        while (!got && cyc <= 60) begin
            #1;
            if (stall_o) stalls++;
            if (done_o) begin
                got = 1'b1;
                er  = exp_q.pop_front();
                erd = exp_rd_q.pop_front();
                check("result", result_o, er);
                check("write_addr", 32'(write_addr_o), 32'(erd));
                check("regwrite", 32'(RegWrite_o), 32'(erd != 0));
                check("latency", cyc, exp_lat);
                check("stall_cycles", stalls, exp_lat);
            end else begin
                if (cyc == 10 && exp_lat == 33)
                    check("busy_outputs", {busy_o, 26'b0, write_addr_o}, 32'h80000000);
                if (cyc == 11 && exp_lat == 33) check("busy_result", result_o, 32'h0);
                @(posedge clk);
                #1;
                if (!keep_start) start_i = 1'b0;
                if (scramble) begin
                    operand_a_i = $urandom;
                    operand_b_i = $urandom;
                    funct3_i    = 3'($urandom_range(0, 7));
                    rd_addr_i   = 5'($urandom_range(0, 31));
                end
                cyc++;
                @(negedge clk);
            end
        end
        if (!got) begin
            check("done_timeout", 32'(cyc), 32'(exp_lat));
            void'(exp_q.pop_front());
            void'(exp_rd_q.pop_front());
        end
    endtask

    initial begin
        int spurious;
        rst = 1'b1; start_i = 1'b0; funct3_i = '0; rd_addr_i = '0;
        operand_a_i = '0; operand_b_i = '0;
        #1;
        check("reset_ctrl", {28'b0, stall_o, busy_o, done_o, RegWrite_o}, 32'h0);
        check("reset_result", result_o, 32'h0);
        check("reset_waddr", 32'(write_addr_o), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(3'b000, 5'd5, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op(3'b001, 5'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(3'b010, 5'd7, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(3'b011, 5'd8, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(3'b100, 5'd9, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        run_op(3'b110, 5'd10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        run_op(3'b101, 5'd11, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
        run_op(3'b111, 5'd12, 32'd9, 32'd0, 1'b0, 1'b0);
        run_op(3'b100, 5'd13, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(3'b110, 5'd14, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(3'b100, 5'd15, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
        run_op(3'b110, 5'd16, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
        run_op(3'b000, 5'd17, 32'd0, 32'h12345678, 1'b0, 1'b0);

        // Reset in the middle of a DIV, after ten iterations.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b100; rd_addr_i = 5'd9;
        operand_a_i = 32'hFFFFFF9C; operand_b_i = 32'd7;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy_o), 32'h1);
        rst = 1'b1;
        #1;
        check("midreset_ctrl", {28'b0, stall_o, busy_o, done_o, RegWrite_o}, 32'h0);
        check("midreset_result", result_o, 32'h0);
        check("midreset_waddr", 32'(write_addr_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (RegWrite_o || done_o) spurious++;
        end
        check("no_write_after_reset", 32'(spurious), 32'h0);
        run_op(3'b101, 5'd18, 32'd100, 32'd7, 1'b0, 1'b0);

        // start_i held across both instructions; second writes rd=0.
        run_op(3'b011, 5'd3, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0);
        run_op(3'b110, 5'd0, 32'h00001234, 32'hFFFFFFF0, 1'b0, 1'b0);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done_o || busy_o) spurious++;
        end
        check("no_restart", 32'(spurious), 32'h0);

        // Inputs scrambled every cycle after acceptance.
        run_op(3'b100, 5'd20, 32'd1000, 32'hFFFFFFFD, 1'b0, 1'b1);
        run_op(3'b001, 5'd21, 32'h7FFFFFFF, 32'h80000001, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++)
            run_op(3'($urandom_range(0, 7)), 5'($urandom_range(1, 31)), $urandom, $urandom, 1'b0, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
